reduce_engine: RTL

//  Streaming multi-lane reduction unit. Consumes LANES elements per beat over a

---
 rtl/reduce_pkg.sv | 26 ++
 rtl/reduce_lane_tree.sv | 87 ++++++++
 rtl/reduce_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the streaming reduction engine: reduction mode
// codes, FSM state encoding and a constant-width helper.
package reduce_pkg;

    // Reduction modes as carried on cfg_mode; code 3 is reserved and folds as SUM.
    localparam logic [1:0] RED_SUM = 2'd0;
    localparam logic [1:0] RED_MAX = 2'd1;
    localparam logic [1:0] RED_MIN = 2'd2;

    // ACC folds beats of the current block; HOLD presents the finished result.
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/reduce_lane_tree.sv
// Combinational per-beat reduction: extends each kept lane to the accumulator
// width and folds all kept lanes of one beat into a single partial result.
module reduce_lane_tree
    import reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48,
    parameter int KC_W   = clog2(LANES + 1)
) (
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic [LANES-1:0]        keep_i,
    input  logic [1:0]              mode_i,
    input  logic                    signed_i,
    output logic [ACC_W-1:0]        partial_o,
    output logic [KC_W-1:0]         kept_cnt_o,
    output logic                    any_kept_o,
    output logic                    ovf_o
);

    logic [ACC_W-1:0] elem;

    // Sign- or zero-extend one element to the accumulator width.
    function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] raw, input logic sgn);
        logic signed [DATA_W-1:0] sraw;
        sraw = raw;
        if (sgn) begin
            return ACC_W'(sraw);
        end
        return ACC_W'(raw);
    endfunction

    // True when a + b leaves the ACC_W range in the chosen signedness.
    function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                     input logic sgn);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sgn) begin
            return (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
        end
        return sum[ACC_W];
    endfunction

    // True when cand strictly beats cur; ties keep the current value.
    function automatic logic wins(input logic [ACC_W-1:0] cand, input logic [ACC_W-1:0] cur,
                                  input logic sgn, input logic want_max);
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(cand) > $signed(cur);
            lt = $signed(cand) < $signed(cur);
        end else begin
            gt = cand > cur;
            lt = cand < cur;
        end
        return want_max ? gt : lt;
    endfunction

    // Walk the lanes in order, folding every kept element into the partial.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        partial_o  = '0;
        kept_cnt_o = '0;
        any_kept_o = 1'b0;
        ovf_o      = 1'b0;
        elem       = '0;
        for (int k = 0; k < LANES; k++) begin
            elem = extend(data_i[k*DATA_W +: DATA_W], signed_i);
            if (keep_i[k]) begin
                case (mode_i)
                    RED_MAX, RED_MIN: begin
                        if (!any_kept_o || wins(elem, partial_o, signed_i, mode_i == RED_MAX)) begin
                            partial_o = elem;
                        end
                    end
                    default: begin
                        ovf_o     = ovf_o | add_ovf(partial_o, elem, signed_i);
                        partial_o = partial_o + elem;
                    end
                endcase
                kept_cnt_o = kept_cnt_o + KC_W'(1);
                any_kept_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reduce_engine.sv
// Streaming multi-lane reduction unit: folds a block of beats into one
// SUM/MAX/MIN result and holds it on a valid/ready output until taken.
module reduce_engine
    import reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  cfg_mode,
    input  logic                        cfg_signed,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic [LANES*DATA_W-1:0]     in_data,
    input  logic [LANES-1:0]            in_keep,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic [LEN_W+clog2(LANES):0] out_count,
    output logic                        out_ovf,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int CNT_W = LEN_W + clog2(LANES) + 1;
    localparam int KC_W  = clog2(LANES + 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               any_q, any_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               signed_q, signed_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic               fire;
    logic               first_beat;
    logic               final_beat;
    logic [1:0]         eff_mode;
    logic               eff_signed;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   len_m1;

    logic [ACC_W-1:0]   tree_partial;
    logic [KC_W-1:0]    tree_kept;
    logic               tree_any;
    logic               tree_ovf;

    // Same overflow rule as the lane tree, applied to the block accumulator.
    function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                     input logic sgn);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sgn) begin
            return (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
        end
        return sum[ACC_W];
    endfunction

    // Strict comparison so ties leave the accumulator untouched.
    function automatic logic wins(input logic [ACC_W-1:0] cand, input logic [ACC_W-1:0] cur,
                                  input logic sgn, input logic want_max);
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(cand) > $signed(cur);
            lt = $signed(cand) < $signed(cur);
        end else begin
            gt = cand > cur;
            lt = cand < cur;
        end
        return want_max ? gt : lt;
    endfunction

    // The first beat of a block uses live configuration; later beats use the latched copy.
    assign fire       = in_valid && (state_q == ST_ACC);
    assign first_beat = (beat_cnt_q == '0);
    assign eff_mode   = first_beat ? cfg_mode   : mode_q;
    assign eff_signed = first_beat ? cfg_signed : signed_q;
    assign eff_len    = first_beat ? cfg_len    : len_q;
    // A length of 0 wraps to all ones here, giving the full 2**LEN_W beat block.
    assign len_m1     = eff_len - LEN_W'(1);
    assign final_beat = (beat_cnt_q == len_m1) || in_last;

    reduce_lane_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W),
        .KC_W   (KC_W)
    ) u_lane_tree (
        .data_i     (in_data),
        .keep_i     (in_keep),
        .mode_i     (eff_mode),
        .signed_i   (eff_signed),
        .partial_o  (tree_partial),
        .kept_cnt_o (tree_kept),
        .any_kept_o (tree_any),
        .ovf_o      (tree_ovf)
    );

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (fire && final_beat) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Fold each accepted beat into the block state; clear it when the result is taken.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        any_d      = any_q;
        beat_cnt_d = beat_cnt_q;
        mode_d     = mode_q;
        signed_d   = signed_q;
        len_d      = len_q;
        if (fire) begin
            if (first_beat) begin
                mode_d   = cfg_mode;
                signed_d = cfg_signed;
                len_d    = cfg_len;
            end
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
            cnt_d      = cnt_q + CNT_W'(tree_kept);
            any_d      = any_q | tree_any;
            case (eff_mode)
                RED_MAX, RED_MIN: begin
                    if (tree_any &&
                        (!any_q || wins(tree_partial, acc_q, eff_signed, eff_mode == RED_MAX))) begin
                        acc_d = tree_partial;
                    end
                end
                default: begin
                    acc_d = acc_q + tree_partial;
                    ovf_d = ovf_q | tree_ovf | add_ovf(acc_q, tree_partial, eff_signed);
                end
            endcase
        end else if ((state_q == ST_HOLD) && out_ready) begin
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            any_d      = 1'b0;
            beat_cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous reset; reset discards any partial block.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            any_q      <= 1'b0;
            beat_cnt_q <= '0;
            mode_q     <= RED_SUM;
            signed_q   <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            any_q      <= any_d;
            beat_cnt_q <= beat_cnt_d;
            mode_q     <= mode_d;
            signed_q   <= signed_d;
            len_q      <= len_d;
        end
    end

    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule
